// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side arbiter.
package fifo_rd_pkg;

    // Arbiter FSM: IDLE arbitrates for one cycle, BURST pops the granted source.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

    // Width needed to index n sources; never narrower than one bit.
    function automatic int src_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, with wrap.
module fifo_rr_pick
    import fifo_rd_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = src_idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last_grant,
    output logic               pick_valid,
    output logic [SRC_W-1:0]   pick_idx
);

    // Scan last_grant+1 .. last_grant+NUM_SRC (mod NUM_SRC); keep the first hit.
    always_comb begin : pick_scan
        logic [SRC_W-1:0] cand_idx_s;
        logic             hit_s;
        pick_valid = 1'b0;
        pick_idx   = {SRC_W{1'b0}};
        cand_idx_s = {SRC_W{1'b0}};
        hit_s      = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand_idx_s = SRC_W'((int'(last_grant) + k) % NUM_SRC);
            hit_s      = !pick_valid && req[cand_idx_s];
            pick_idx   = hit_s ? cand_idx_s : pick_idx;
            pick_valid = pick_valid | hit_s;
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side scheduler: drains several FIFO read ports into one valid/ready
// stream, round-robin with a bounded burst per grant and a one-entry output stage.
module fifo_rd_arbiter
    import fifo_rd_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4,
    parameter int SRC_W      = src_idx_width(NUM_SRC),
    parameter int CNT_W      = $clog2(BURST_MAX + 1)
) (
    input  logic                          r_clk,
    input  logic                          r_rst,
    input  logic [NUM_SRC-1:0]            src_empty,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_rdata,
    output logic [NUM_SRC-1:0]            src_rinc,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic [SRC_W-1:0]              m_src
);

    rd_state_e             state_r;
    logic [SRC_W-1:0]      grant_r;
    logic [SRC_W-1:0]      last_grant_r;
    logic [CNT_W-1:0]      burst_cnt_r;

    logic                  can_load_s;
    logic                  grant_empty_s;
    logic                  pop_s;
    logic [CNT_W-1:0]      cnt_next_s;
    logic                  pick_valid_s;
    logic [SRC_W-1:0]      pick_idx_s;
    logic [DATA_WIDTH-1:0] head_data_s;

    fifo_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req        (~src_empty),
        .last_grant (last_grant_r),
        .pick_valid (pick_valid_s),
        .pick_idx   (pick_idx_s)
    );

    // Pop qualification: the output stage can take a word and the granted FIFO holds one.
    always_comb begin
        can_load_s    = !m_valid || m_ready;
        grant_empty_s = src_empty[grant_r];
        pop_s         = (state_r == BURST) && !grant_empty_s && can_load_s;
        cnt_next_s    = burst_cnt_r + CNT_W'(1);
    end

    // Head-of-FIFO word of the granted source; only ever feeds the output register.
    always_comb begin
        head_data_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            head_data_s = (grant_r == SRC_W'(i)) ? src_rdata[i*DATA_WIDTH +: DATA_WIDTH]
                                                 : head_data_s;
        end
    end

    // One-hot pop strobe to the granted source; zero whenever no pop is allowed.
    always_comb begin
        src_rinc = {NUM_SRC{1'b0}};
        if (pop_s) begin
            src_rinc[grant_r] = 1'b1;
        end else begin
            src_rinc = {NUM_SRC{1'b0}};
        end
    end

    // Arbitration FSM: grant, burst counter and round-robin pointer.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            state_r      <= IDLE;
            grant_r      <= {SRC_W{1'b0}};
            last_grant_r <= SRC_W'(NUM_SRC - 1);
            burst_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        grant_r     <= pick_idx_s;
                        burst_cnt_r <= {CNT_W{1'b0}};
                        state_r     <= BURST;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                BURST: begin
                    if (pop_s) begin
                        burst_cnt_r <= cnt_next_s;
                        if (cnt_next_s == CNT_W'(BURST_MAX)) begin
                            state_r      <= IDLE;
                            last_grant_r <= grant_r;
                        end else begin
                            state_r      <= BURST;
                        end
                    end else if (grant_empty_s) begin
                        // Source drained before the burst limit: hand the turn on.
                        state_r      <= IDLE;
                        last_grant_r <= grant_r;
                    end else begin
                        // Waiting on backpressure; keep the grant.
                        state_r      <= BURST;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    last_grant_r <= grant_r;
                end
            endcase
        end
    end

    // Output stage: load on pop (replacing an accepted word), clear when taken with no refill.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            m_valid <= 1'b0;
            m_data  <= {DATA_WIDTH{1'b0}};
            m_src   <= {SRC_W{1'b0}};
        end else begin
            if (pop_s) begin
                m_valid <= 1'b1;
                m_data  <= head_data_s;
                m_src   <= grant_r;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end else begin
                m_valid <= m_valid;
            end
        end
    end

endmodule
